// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one load/store per enable over a ready-handshake
// bus, aligns/extends load data and presents a registered writeback bundle.
module mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [5:0]         rd,
    input  logic               regwrite,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [1:0]         mem_size,
    input  logic               mem_unsigned,
    input  logic [31:0]        aluresult,
    input  logic [31:0]        result,
    input  logic [31:0]        rdata1,
    mem_stage_if.master        dmem,
    output logic               fin,
    output logic               busy,
    output logic [5:0]         wb_rd,
    output logic               wb_regwrite,
    output logic [31:0]        wb_data,
    output logic [1:0]         err
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   wait_cnt_reg;

    // Operation context captured at enable, used when the access completes
    logic [5:0]      rd_reg;
    logic            regwrite_reg;
    logic            load_reg;
    logic [1:0]      size_reg;
    logic            unsigned_reg;
    logic [1:0]      addr_lo_reg;
    logic [31:0]     result_reg;

    logic            mem_op_in;
    logic            store_op_in;
    logic            misaligned_in;
    logic [3:0]      strb_in;
    logic [31:0]     wdata_in;

    logic [7:0]      byte_lane [4];
    logic [15:0]     half_lane [2];
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [31:0]     load_data;

    assign mem_op_in   = memread | memwrite;
    // A load wins when both are requested; the store side is suppressed
    assign store_op_in = memwrite & ~memread;

    always_comb begin
        misaligned_in = 1'b0;
        case (mem_size)
            2'd0:    misaligned_in = 1'b0;
            2'd1:    misaligned_in = aluresult[0];
            2'd2:    misaligned_in = |aluresult[1:0];
            default: misaligned_in = 1'b1;
        endcase
    end

    always_comb begin
        strb_in  = 4'b1111;
        wdata_in = rdata1;
        case (mem_size)
            2'd0: begin
                strb_in  = 4'b0001 << aluresult[1:0];
                wdata_in = {4{rdata1[7:0]}};
            end
            2'd1: begin
                strb_in  = 4'b0011 << aluresult[1:0];
                wdata_in = {2{rdata1[15:0]}};
            end
            default: begin
                strb_in  = 4'b1111;
                wdata_in = rdata1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = dmem.dmem_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = dmem.dmem_rdata[16*gi +: 16];
        end
    endgenerate

    assign load_byte = byte_lane[addr_lo_reg];
    assign load_half = half_lane[addr_lo_reg[1]];

    always_comb begin
        load_data = dmem.dmem_rdata;
        case (size_reg)
            2'd0:    load_data = unsigned_reg ? {24'd0, load_byte}
                                              : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_data = unsigned_reg ? {16'd0, load_half}
                                              : {{16{load_half[15]}}, load_half};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            rd_reg          <= '0;
            regwrite_reg    <= 1'b0;
            load_reg        <= 1'b0;
            size_reg        <= '0;
            unsigned_reg    <= 1'b0;
            addr_lo_reg     <= '0;
            result_reg      <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= '0;
            fin             <= 1'b0;
            busy            <= 1'b0;
            wb_rd           <= '0;
            wb_regwrite     <= 1'b0;
            wb_data         <= '0;
            err             <= ERR_NONE;
        end else begin
            case (state_reg)
                IDLE: begin
                    fin <= 1'b0;
                    if (enable) begin
                        busy         <= 1'b1;
                        rd_reg       <= rd;
                        regwrite_reg <= regwrite;
                        load_reg     <= memread;
                        size_reg     <= mem_size;
                        unsigned_reg <= mem_unsigned;
                        addr_lo_reg  <= aluresult[1:0];
                        result_reg   <= result;
                        if (mem_op_in && !misaligned_in) begin
                            state_reg       <= ACCESS;
                            wait_cnt_reg    <= '0;
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= store_op_in;
                            dmem.dmem_addr  <= {aluresult[31:2], 2'b00};
                            dmem.dmem_wdata <= wdata_in;
                            dmem.dmem_wstrb <= store_op_in ? strb_in : 4'b0000;
                        end else begin
                            // Non-memory op, or a memory op rejected for alignment
                            state_reg   <= DONE;
                            fin         <= 1'b1;
                            wb_rd       <= rd;
                            wb_data     <= result;
                            wb_regwrite <= mem_op_in ? 1'b0 : regwrite;
                            err         <= mem_op_in ? ERR_ALIGN : ERR_NONE;
                        end
                    end
                end

                ACCESS: begin
                    if (dmem.dmem_ready) begin
                        state_reg       <= DONE;
                        dmem.dmem_req   <= 1'b0;
                        dmem.dmem_we    <= 1'b0;
                        dmem.dmem_wstrb <= 4'b0000;
                        fin             <= 1'b1;
                        wb_rd           <= rd_reg;
                        wb_data         <= load_reg ? load_data : result_reg;
                        wb_regwrite     <= load_reg & regwrite_reg;
                        err             <= ERR_NONE;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        state_reg       <= DONE;
                        wait_cnt_reg    <= wait_cnt_reg + 1'b1;
                        dmem.dmem_req   <= 1'b0;
                        dmem.dmem_we    <= 1'b0;
                        dmem.dmem_wstrb <= 4'b0000;
                        fin             <= 1'b1;
                        wb_rd           <= rd_reg;
                        wb_data         <= result_reg;
                        wb_regwrite     <= 1'b0;
                        err             <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    fin       <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    fin       <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, loads, stores,
// alignment errors, timeout and reset during an access.
module tb_mem_stage;
    logic        clk;
    logic        rstn;
    logic        enable;
    logic [5:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] aluresult;
    logic [31:0] result;
    logic [31:0] rdata1;
    logic        fin;
    logic        busy;
    logic [5:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic [1:0]  err;

    int checks;
    int failures;

    mem_stage_if dmem_bus ();

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .rd           (rd),
        .regwrite     (regwrite),
        .memread      (memread),
        .memwrite     (memwrite),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .aluresult    (aluresult),
        .result       (result),
        .rdata1       (rdata1),
        .dmem         (dmem_bus),
        .fin          (fin),
        .busy         (busy),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_data      (wb_data),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        enable              = 1'b0;
        rd                  = 6'd0;
        regwrite            = 1'b0;
        memread             = 1'b0;
        memwrite            = 1'b0;
        mem_size            = 2'd0;
        mem_unsigned        = 1'b0;
        aluresult           = 32'd0;
        result              = 32'd0;
        rdata1              = 32'd0;
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b1;
        tick();
        checks++; if (fin !== 1'b0) begin failures++; $display("FAIL reset_fin got=%b exp=0", fin); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_bus.dmem_req); end
        checks++; if (dmem_bus.dmem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", dmem_bus.dmem_we); end
        checks++; if (dmem_bus.dmem_wstrb !== 4'b0000) begin failures++; $display("FAIL reset_wstrb got=%b exp=0000", dmem_bus.dmem_wstrb); end
        checks++; if ({wb_rd, wb_regwrite, wb_data, err} !== 41'd0) begin failures++; $display("FAIL reset_wb got=%h/%b/%h/%0d exp=0", wb_rd, wb_regwrite, wb_data, err); end
        rstn = 1'b0;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_nonmem();
        rd = 6'd5; regwrite = 1'b1; result = 32'h1234_5678;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL nonmem_fin got=%b exp=1", fin); end
        checks++; if (wb_data !== 32'h1234_5678) begin failures++; $display("FAIL nonmem_data got=%h exp=12345678", wb_data); end
        checks++; if (wb_rd !== 6'd5) begin failures++; $display("FAIL nonmem_rd got=%0d exp=5", wb_rd); end
        checks++; if (wb_regwrite !== 1'b1) begin failures++; $display("FAIL nonmem_regwrite got=%b exp=1", wb_regwrite); end
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL nonmem_req got=%b exp=0", dmem_bus.dmem_req); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nonmem_busy got=%b exp=1", busy); end
        result = 32'hFFFF_0000;
        tick();
        checks++; if (fin !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL nonmem_end got=fin%b/busy%b exp=0/0", fin, busy); end
        checks++; if (wb_data !== 32'h1234_5678) begin failures++; $display("FAIL nonmem_hold got=%h exp=12345678", wb_data); end
        $display("txn nonmem rd=%0d data=%h", wb_rd, wb_data);
    endtask

    task automatic test_load_byte();
        clear_inputs();
        rd = 6'd7; regwrite = 1'b1; memread = 1'b1; mem_size = 2'd0;
        aluresult = 32'h0000_0103; result = 32'h0000_DEAD;
        enable = 1'b1;
        tick();
        // enable while busy with different context must be ignored
        rd = 6'd9; aluresult = 32'h0000_0400;
        checks++; if (dmem_bus.dmem_req !== 1'b1) begin failures++; $display("FAIL ldb_req got=%b exp=1", dmem_bus.dmem_req); end
        checks++; if (dmem_bus.dmem_addr !== 32'h0000_0100) begin failures++; $display("FAIL ldb_addr got=%h exp=00000100", dmem_bus.dmem_addr); end
        checks++; if (dmem_bus.dmem_we !== 1'b0) begin failures++; $display("FAIL ldb_we got=%b exp=0", dmem_bus.dmem_we); end
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 32'h0000_0100) begin failures++; $display("FAIL ldb_hold got=%b/%h exp=1/00000100", dmem_bus.dmem_req, dmem_bus.dmem_addr); end
        checks++; if (fin !== 1'b0) begin failures++; $display("FAIL ldb_early_fin got=%b exp=0", fin); end
        tick();
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h80FF_FF00;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL ldb_fin got=%b exp=1", fin); end
        checks++; if (wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL ldb_data got=%h exp=ffffff80", wb_data); end
        checks++; if (wb_rd !== 6'd7) begin failures++; $display("FAIL ldb_rd got=%0d exp=7", wb_rd); end
        checks++; if (wb_regwrite !== 1'b1 || err !== 2'd0) begin failures++; $display("FAIL ldb_wb got=%b/%0d exp=1/0", wb_regwrite, err); end
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL ldb_req_drop got=%b exp=0", dmem_bus.dmem_req); end
        tick();
        checks++; if (fin !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ldb_end got=fin%b/busy%b exp=0/0", fin, busy); end
        tick();
        checks++; if (dmem_bus.dmem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ldb_no_restart got=req%b/busy%b exp=0/0", dmem_bus.dmem_req, busy); end
        $display("txn load byte addr=00000103 data=%h", wb_data);
    endtask

    task automatic test_load_half_unsigned();
        clear_inputs();
        rd = 6'd3; regwrite = 1'b1; memread = 1'b1; mem_size = 2'd1; mem_unsigned = 1'b1;
        aluresult = 32'h0000_0202;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h8001_1234;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL ldhu_fin got=%b exp=1", fin); end
        checks++; if (wb_data !== 32'h0000_8001) begin failures++; $display("FAIL ldhu_data got=%h exp=00008001", wb_data); end
        tick();
        $display("txn load half unsigned addr=00000202 data=%h", wb_data);
    endtask

    task automatic test_store_half();
        clear_inputs();
        rd = 6'd4; regwrite = 1'b1; memwrite = 1'b1; mem_size = 2'd1;
        aluresult = 32'h0000_0102; rdata1 = 32'hAAAA_BEEF;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_we !== 1'b1) begin failures++; $display("FAIL sth_we got=%b exp=1", dmem_bus.dmem_we); end
        checks++; if (dmem_bus.dmem_wstrb !== 4'b1100) begin failures++; $display("FAIL sth_wstrb got=%b exp=1100", dmem_bus.dmem_wstrb); end
        checks++; if (dmem_bus.dmem_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sth_wdata got=%h exp=beefbeef", dmem_bus.dmem_wdata); end
        checks++; if (dmem_bus.dmem_addr !== 32'h0000_0100) begin failures++; $display("FAIL sth_addr got=%h exp=00000100", dmem_bus.dmem_addr); end
        dmem_bus.dmem_ready = 1'b1;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        checks++; if (fin !== 1'b1 || wb_regwrite !== 1'b0) begin failures++; $display("FAIL sth_wb got=fin%b/rw%b exp=1/0", fin, wb_regwrite); end
        tick();
        $display("txn store half addr=00000102 wdata=beefbeef");
    endtask

    task automatic test_store_byte_word();
        clear_inputs();
        memwrite = 1'b1; mem_size = 2'd0; aluresult = 32'h0000_0101; rdata1 = 32'h1234_5678;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_wstrb !== 4'b0010) begin failures++; $display("FAIL stb_wstrb got=%b exp=0010", dmem_bus.dmem_wstrb); end
        checks++; if (dmem_bus.dmem_wdata !== 32'h7878_7878) begin failures++; $display("FAIL stb_wdata got=%h exp=78787878", dmem_bus.dmem_wdata); end
        dmem_bus.dmem_ready = 1'b1;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        tick();
        $display("txn store byte addr=00000101");
        mem_size = 2'd2; aluresult = 32'h0000_0200; rdata1 = 32'hCAFE_BABE;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_wstrb !== 4'b1111 || dmem_bus.dmem_wdata !== 32'hCAFE_BABE) begin failures++; $display("FAIL stw got=%b/%h exp=1111/cafebabe", dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata); end
        dmem_bus.dmem_ready = 1'b1;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        tick();
        $display("txn store word addr=00000200");
    endtask

    task automatic test_load_and_store();
        clear_inputs();
        rd = 6'd11; regwrite = 1'b1; memread = 1'b1; memwrite = 1'b1; mem_size = 2'd2;
        aluresult = 32'h0000_0010; rdata1 = 32'h1111_1111;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_we !== 1'b0 || dmem_bus.dmem_wstrb !== 4'b0000) begin failures++; $display("FAIL ldst_we got=%b/%b exp=0/0000", dmem_bus.dmem_we, dmem_bus.dmem_wstrb); end
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        checks++; if (wb_data !== 32'hCAFE_F00D || wb_regwrite !== 1'b1) begin failures++; $display("FAIL ldst_wb got=%h/%b exp=cafef00d/1", wb_data, wb_regwrite); end
        tick();
        $display("txn load+store addr=00000010 data=%h", wb_data);
    endtask

    task automatic test_misaligned();
        clear_inputs();
        rd = 6'd2; regwrite = 1'b1; memread = 1'b1; mem_size = 2'd2; aluresult = 32'h0000_0101;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", dmem_bus.dmem_req); end
        checks++; if (fin !== 1'b1 || err !== 2'd1 || wb_regwrite !== 1'b0) begin failures++; $display("FAIL mis_wb got=fin%b/err%0d/rw%b exp=1/1/0", fin, err, wb_regwrite); end
        tick();
        checks++; if (err !== 2'd1) begin failures++; $display("FAIL mis_err_hold got=%0d exp=1", err); end
        $display("txn misaligned word load addr=00000101 err=%0d", err);
        mem_size = 2'd3; aluresult = 32'h0000_0100;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (fin !== 1'b1 || err !== 2'd1 || dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL rsv_size got=fin%b/err%0d/req%b exp=1/1/0", fin, err, dmem_bus.dmem_req); end
        tick();
        $display("txn reserved size load err=%0d", err);
    endtask

    task automatic test_timeout();
        clear_inputs();
        rd = 6'd6; regwrite = 1'b1; memread = 1'b1; mem_size = 2'd2; aluresult = 32'h0000_0040;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (fin !== 1'b0 || dmem_bus.dmem_req !== 1'b1) begin failures++; $display("FAIL tmo_wait%0d got=fin%b/req%b exp=0/1", i, fin, dmem_bus.dmem_req); end
        end
        tick();
        checks++; if (fin !== 1'b1 || err !== 2'd2) begin failures++; $display("FAIL tmo_fin got=fin%b/err%0d exp=1/2", fin, err); end
        checks++; if (wb_regwrite !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL tmo_drop got=rw%b/req%b exp=0/0", wb_regwrite, dmem_bus.dmem_req); end
        tick();
        checks++; if (dmem_bus.dmem_req !== 1'b0 || fin !== 1'b0) begin failures++; $display("FAIL tmo_after got=req%b/fin%b exp=0/0", dmem_bus.dmem_req, fin); end
        $display("txn timeout addr=00000040 err=%0d", err);
    endtask

    task automatic test_reset_mid_access();
        clear_inputs();
        rd = 6'd8; regwrite = 1'b1; memread = 1'b1; mem_size = 2'd2; aluresult = 32'h0000_0300;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (dmem_bus.dmem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_req_pre got=%b exp=1", dmem_bus.dmem_req); end
        #2;
        rstn = 1'b1;
        #1;
        checks++; if (dmem_bus.dmem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async got=req%b/busy%b exp=0/0", dmem_bus.dmem_req, busy); end
        dmem_bus.dmem_ready = 1'b1;
        tick();
        checks++; if (fin !== 1'b0) begin failures++; $display("FAIL rst_mid_nofin got=%b exp=0", fin); end
        dmem_bus.dmem_ready = 1'b0;
        rstn = 1'b0;
        tick();
        checks++; if (fin !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_release got=fin%b/req%b exp=0/0", fin, dmem_bus.dmem_req); end
        clear_inputs();
        rd = 6'd12; regwrite = 1'b1; result = 32'h0BAD_F00D;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++; if (fin !== 1'b1 || wb_data !== 32'h0BAD_F00D || wb_rd !== 6'd12) begin failures++; $display("FAIL rst_mid_resume got=fin%b/%h/%0d exp=1/0badf00d/12", fin, wb_data, wb_rd); end
        tick();
        $display("txn reset mid-access then nonmem data=%h", wb_data);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b1;
        clear_inputs();
        test_reset();
        test_nonmem();
        test_load_byte();
        test_load_half_unsigned();
        test_store_half();
        test_store_byte_word();
        test_load_and_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MAX_WAIT, 255, maximum cycles to wait for dmem_ready before abort.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-high (1 = reset).
REQ-004 enable  input  1  pipeline controller starts one operation.
REQ-005 rd  input  6  destination register from execute stage.
REQ-006 regwrite  input  1  operation writes a register.
REQ-007 memread  input  1  load operation.
REQ-008 memwrite  input  1  store operation.
REQ-009 mem_size  input  2  access size: 0 byte, 1 half, 2 word (3 reserved).
REQ-010 mem_unsigned  input  1  zero-extend loads when 1, else sign-extend.
REQ-011 aluresult  input  32  effective address.
REQ-012 result  input  32  ALU/FPU result, passed through for non-load ops.
REQ-013 rdata1  input  32  store data.
REQ-014 dmem_req  output  1  data memory request.
REQ-015 dmem_we  output  1  write enable of the request.
REQ-016 dmem_addr  output  32  word address {aluresult[31:2],2'b00}.
REQ-017 dmem_wdata  output  32  store data replicated into lanes.
REQ-018 dmem_wstrb  output  4  byte strobes.
REQ-019 dmem_ready  input  1  memory accepts/completes request this cycle.
REQ-020 dmem_rdata  input  32  load data, valid when dmem_ready=1.
REQ-021 fin  output  1  one-cycle pulse: operation complete, wb_* valid.
REQ-022 busy  output  1  operation in progress.
REQ-023 wb_rd, wb_regwrite, wb_data  output  6,1,32  writeback bundle, registered.
REQ-024 err  output  2  0 none, 1 misaligned/reserved size, 2 timeout; valid with fin.

Function
REQ-025 FSM states IDLE, ACCESS, DONE; busy=1 in ACCESS and DONE.
REQ-026 IDLE + enable: capture all inputs; memread|memwrite with legal alignment -> ACCESS; otherwise -> DONE.
REQ-027 enable while busy SHALL be ignored; no input recaptured.
REQ-028 memread and memwrite both set: load performed, store suppressed.
REQ-029 Alignment: half needs addr[0]=0, word needs addr[1:0]=0; violation or mem_size=3 -> DONE, err=1, no dmem_req, wb_regwrite=0.
REQ-030 ACCESS: dmem_req=1 and dmem_addr/we/wdata/wstrb held stable until the cycle dmem_ready=1, then -> DONE.
REQ-031 Store strobes: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; wdata byte {4{rdata1[7:0]}}, half {2{rdata1[15:0]}}.
REQ-032 Load: select lane by addr[1:0], extend per mem_unsigned into wb_data, captured on dmem_ready.
REQ-033 Wait counter: cleared on ACCESS entry, incremented each cycle without ready; reaching MAX_WAIT -> DONE, err=2, dmem_req dropped, wb_regwrite=0.
REQ-034 DONE lasts exactly one cycle: fin=1, then IDLE.
REQ-035 Non-memory op: wb_data=result, wb_rd=rd, wb_regwrite=regwrite; fin one cycle after enable.
REQ-036 Memory op latency: dmem_req rises cycle after enable; fin the cycle after dmem_ready.
REQ-037 Store: wb_regwrite=0 regardless of regwrite.
REQ-038 wb_* and err SHALL hold their values until next fin.

Reset
REQ-039 rstn=1 SHALL immediately force IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, fin=0, busy=0, wb_regwrite=0, wb_rd=0, wb_data=0, err=0, counter=0.
REQ-040 Reset during ACCESS SHALL abandon the request with no fin pulse.

Verification
REQ-041 Non-mem: enable, result=0x12345678, rd=5, regwrite=1 -> next cycle fin=1, wb_data=0x12345678, wb_rd=5, no dmem_req.
REQ-042 Signed byte load: addr=0x103, dmem_rdata=0x80FFFF00, ready after 3 cycles -> dmem_addr=0x100, wb_data=0xFFFFFF80, fin cycle after ready.
REQ-043 Half store: addr=0x102, rdata1=0xAAAABEEF -> dmem_we=1, wstrb=4'b1100, wdata=0xBEEFBEEF, wb_regwrite=0.
REQ-044 Misaligned word load addr=0x101 -> no dmem_req, fin next cycle, err=1, wb_regwrite=0.
REQ-045 Timeout: MAX_WAIT=4, dmem_ready held 0 -> fin after 4 wait cycles, err=2, dmem_req low thereafter.
REQ-046 Reset asserted mid-ACCESS -> dmem_req=0 same cycle, no fin; new enable after release completes normally.
